// File: rtl/alu_input_sequencer.sv
// alu_input_sequencer
// Captures operand A, operand B and the opcode from a shared switch bus, one
// push-button per item and in a fixed order. The captured values drive the ALU
// directly. On execute, the ALU result is latched with a one-cycle valid strobe.
// Each raw button passes through a 2-flop synchroniser and a rising-edge
// detector, so a press gives exactly one pulse however long it is held.
//
// Handshake: o_valid is a strobe with no ready. It is high for exactly the one
// cycle after o_result was written, and o_result then holds until the next
// execute.
module alu_input_sequencer #(
    parameter int NB_DATA = 16,
    parameter int NB_OP   = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_btn_a,
    input  logic               i_btn_b,
    input  logic               i_btn_op,
    input  logic [NB_DATA-1:0] i_result,
    output logic [NB_DATA-1:0] o_dataA,
    output logic [NB_DATA-1:0] o_dataB,
    output logic [NB_OP-1:0]   o_sel,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_valid,
    output logic [1:0]         o_state
);

    localparam logic [1:0] ST_A    = 2'b00;
    localparam logic [1:0] ST_B    = 2'b01;
    localparam logic [1:0] ST_OP   = 2'b10;
    localparam logic [1:0] ST_EXEC = 2'b11;

    // Per button: [0] and [1] are the synchroniser, and [2] is the
    // edge-detect history.
    logic [2:0] sync_a;
    logic [2:0] sync_b;
    logic [2:0] sync_op;

    logic pulse_a;
    logic pulse_b;
    logic pulse_op;

    logic [1:0] state;

    // Shift the raw buttons through the synchroniser and edge-history flops.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sync_a  <= 3'b000;
            sync_b  <= 3'b000;
            sync_op <= 3'b000;
        end else begin
            sync_a  <= {sync_a[1:0],  i_btn_a};
            sync_b  <= {sync_b[1:0],  i_btn_b};
            sync_op <= {sync_op[1:0], i_btn_op};
        end
    end

    // Rising-edge pulses, one clock wide per press.
    always_comb begin
        pulse_a  = sync_a[1]  & ~sync_a[2];
        pulse_b  = sync_b[1]  & ~sync_b[2];
        pulse_op = sync_op[1] & ~sync_op[2];
    end

    // Sequencing FSM. Only the pulse matching the current state acts; all
    // other pulses are dropped rather than queued.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state    <= ST_A;
            o_dataA  <= '0;
            o_dataB  <= '0;
            o_sel    <= '0;
            o_result <= '0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                ST_A: begin
                    if (pulse_a) begin
                        o_dataA <= i_data;
                        state   <= ST_B;
                    end
                end
                ST_B: begin
                    if (pulse_b) begin
                        o_dataB <= i_data;
                        state   <= ST_OP;
                    end
                end
                ST_OP: begin
                    if (pulse_op) begin
                        o_sel <= i_data[NB_OP-1:0];
                        state <= ST_EXEC;
                    end
                end
                default: begin
                    // ST_EXEC: the ALU has had this whole cycle to settle
                    // on the new select.
                    o_result <= i_result;
                    o_valid  <= 1'b1;
                    state    <= ST_A;
                end
            endcase
        end
    end

    // Expose the state for the LEDs.
    always_comb begin
        o_state = state;
    end

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Testbench for alu_input_sequencer. The bench holds a small ALU model that
// closes the loop on i_result. Expected values are hand-computed constants.
module tb_alu_input_sequencer;

    logic        i_clock;
    logic        i_reset;
    logic [15:0] i_data;
    logic        i_btn_a;
    logic        i_btn_b;
    logic        i_btn_op;
    logic [15:0] i_result;
    logic [15:0] o_dataA;
    logic [15:0] o_dataB;
    logic [1:0]  o_sel;
    logic [15:0] o_result;
    logic        o_valid;
    logic [1:0]  o_state;

    int n_total;
    int n_pass;
    int valid_cnt;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[4];

    alu_input_sequencer #(.NB_DATA(16), .NB_OP(2)) dut (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_data   (i_data),
        .i_btn_a  (i_btn_a),
        .i_btn_b  (i_btn_b),
        .i_btn_op (i_btn_op),
        .i_result (i_result),
        .o_dataA  (o_dataA),
        .o_dataB  (o_dataB),
        .o_sel    (o_sel),
        .o_result (o_result),
        .o_valid  (o_valid),
        .o_state  (o_state)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    // Downstream combinational ALU model.
    always_comb begin
        case (o_sel)
            2'b00:   i_result = o_dataA + o_dataB;
            2'b01:   i_result = o_dataA - o_dataB;
            2'b10:   i_result = o_dataA & o_dataB;
            default: i_result = o_dataA | o_dataB;
        endcase
    end

    // Count valid strobes, sampled away from the active edge.
    always @(negedge i_clock) begin
        if (o_valid === 1'b1) valid_cnt++;
    end

    // Watchdog that stops a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required end before 200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Assert reset between clock edges. The outputs must clear with no edge.
    task automatic async_reset();
        @(negedge i_clock);
        #2 i_reset = 1'b1;
        #1;
        check("rst dataA", o_dataA, 0);
        check("rst dataB", o_dataB, 0);
        check("rst sel", o_sel, 0);
        check("rst result", o_result, 0);
        check("rst valid", o_valid, 0);
        check("rst state", o_state, 0);
        @(negedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b0;
    endtask

    // Press one button (0=A, 1=B, 2=op) for hold cycles with the given data.
    // The task returns after the load edge (k+2) of a one-cycle press.
    task automatic press(input int which, input logic [15:0] data, input int hold);
        @(negedge i_clock);
        i_data = data;
        case (which)
            0: i_btn_a = 1'b1;
            1: i_btn_b = 1'b1;
            default: i_btn_op = 1'b1;
        endcase
        repeat (hold) @(negedge i_clock);
        i_btn_a  = 1'b0;
        i_btn_b  = 1'b0;
        i_btn_op = 1'b0;
        repeat (2) @(negedge i_clock);
    endtask

    // Press op and measure how many edges after first sampling o_valid rises.
    task automatic execute(input string tag, input logic [1:0] op, input logic [15:0] exp);
        int lat;
        int v0;
        lat = 0;
        v0  = valid_cnt;
        @(negedge i_clock);
        i_data   = {14'd0, op};
        i_btn_op = 1'b1;
        @(negedge i_clock);            // after edge k
        i_btn_op = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge i_clock);        // after edge k+n
            if (n == 2) check({tag, " state exec"}, o_state, 2'b11);
            if (o_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        check({tag, " valid latency"}, lat, 3);
        check({tag, " sel"}, o_sel, op);
        check({tag, " result"}, o_result, exp);
        @(negedge i_clock);            // after edge k+4
        check({tag, " valid one cycle"}, o_valid, 0);
        check({tag, " state back A"}, o_state, 0);
        check({tag, " result held"}, o_result, exp);
        check({tag, " valid count"}, valid_cnt - v0, 1);
    endtask

    initial begin
        int v0;
        n_total   = 0;
        n_pass    = 0;
        valid_cnt = 0;
        i_reset   = 1'b0;
        i_data    = '0;
        i_btn_a   = 1'b0;
        i_btn_b   = 1'b0;
        i_btn_op  = 1'b0;

        vecs[0] = '{a: 16'h0005, b: 16'h0003, op: 2'b00, exp: 16'h0008};
        vecs[1] = '{a: 16'h0003, b: 16'h0005, op: 2'b01, exp: 16'hFFFE};
        vecs[2] = '{a: 16'hF0F0, b: 16'h0FF0, op: 2'b10, exp: 16'h00F0};
        vecs[3] = '{a: 16'h1200, b: 16'h0034, op: 2'b11, exp: 16'h1234};

        // Asynchronous reset applied mid-cycle.
        async_reset();
        repeat (2) @(negedge i_clock);

        // Table-driven full sequences.
        for (int i = 0; i < 4; i++) begin
            press(0, vecs[i].a, 1);
            check($sformatf("v%0d dataA", i), o_dataA, vecs[i].a);
            check($sformatf("v%0d state B", i), o_state, 2'b01);
            press(1, vecs[i].b, 1);
            check($sformatf("v%0d dataB", i), o_dataB, vecs[i].b);
            check($sformatf("v%0d state OP", i), o_state, 2'b10);
            execute($sformatf("v%0d", i), vecs[i].op, vecs[i].exp);
            repeat (2) @(negedge i_clock);
        end

        // Out-of-order presses in ST_A are discarded.
        v0 = valid_cnt;
        press(2, 16'h0001, 1);
        press(1, 16'hBEEF, 1);
        repeat (3) @(negedge i_clock);
        check("ooo state", o_state, 0);
        check("ooo dataA", o_dataA, 16'h1200);
        check("ooo dataB", o_dataB, 16'h0034);
        check("ooo sel", o_sel, 2'b11);
        check("ooo no valid", valid_cnt - v0, 0);

        // A held button loads once. Bus changes during the hold are ignored.
        @(negedge i_clock);
        i_data  = 16'h1111;
        i_btn_a = 1'b1;
        repeat (5) @(negedge i_clock);
        i_data = 16'h2222;
        repeat (15) @(negedge i_clock);
        i_btn_a = 1'b0;
        repeat (3) @(negedge i_clock);
        check("held dataA", o_dataA, 16'h1111);
        check("held state", o_state, 2'b01);

        // Reset in ST_OP aborts the sequence, then a fresh sequence runs.
        async_reset();
        repeat (2) @(negedge i_clock);
        press(0, 16'h00AA, 1);
        press(1, 16'h0055, 1);
        check("pre-abort state", o_state, 2'b10);
        check("pre-abort dataB", o_dataB, 16'h0055);
        v0 = valid_cnt;
        async_reset();
        repeat (4) @(negedge i_clock);
        check("abort state", o_state, 0);
        check("abort dataA", o_dataA, 0);
        check("abort no valid", valid_cnt - v0, 0);
        press(0, 16'h0007, 1);
        press(1, 16'h0002, 1);
        check("fresh dataA", o_dataA, 16'h0007);
        check("fresh dataB", o_dataB, 16'h0002);
        execute("fresh", 2'b01, 16'h0005);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_input_sequencer.md
# alu_input_sequencer

Front-end stage that sits directly upstream of the 2-bit-opcode ALU in the TP1 operation-selector design. Captures operand A, operand B and the operation code from a shared data bus (board switches), one push-button per item, in a fixed order. Drives the ALU operand/select inputs from registers, then latches the ALU's combinational result into an output register with a one-cycle valid strobe. Buttons are asynchronous to the clock; the block synchronises them and edge-detects them.

## Interface
- NB_DATA, 16, width of operands, data bus and result
- NB_OP, 2, width of the operation code fed to the ALU

- i_clock  in  1  system clock, all flops on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_data  in  NB_DATA  switch bus; sampled as A, B, or (low NB_OP bits) opcode
- i_btn_a  in  1  raw, asynchronous "load A" button, active high
- i_btn_b  in  1  raw, asynchronous "load B" button, active high
- i_btn_op  in  1  raw, asynchronous "load op and execute" button, active high
- i_result  in  NB_DATA  combinational result returned by the ALU
- o_dataA  out  NB_DATA  registered operand A to ALU
- o_dataB  out  NB_DATA  registered operand B to ALU
- o_sel  out  NB_OP  registered opcode to ALU (00 add, 01 sub, 10 and, 11 or)
- o_result  out  NB_DATA  registered ALU result, held until next execute
- o_valid  out  1  one-cycle strobe: o_result just updated
- o_state  out  2  current FSM state (for LEDs)

## Operation
- Each button: 2-flop synchroniser, then a third flop; pulse = sync2 & ~sync3 (rising edge only). One pulse per press regardless of hold length.
- FSM states (o_state encoding): ST_A=00, ST_B=01, ST_OP=10, ST_EXEC=11.
- ST_A: on pulse_a, A <= i_data, go ST_B. Else hold.
- ST_B: on pulse_b, B <= i_data, go ST_OP. Else hold.
- ST_OP: on pulse_op, sel <= i_data[NB_OP-1:0], go ST_EXEC. Else hold.
- ST_EXEC: unconditional, one cycle: o_result <= i_result, o_valid <= 1, go ST_A.
- Pulses not matching the current state are discarded (not queued); simultaneous pulses: only the one matching the state acts.
- i_data captured only on the clock edge where the matching pulse is high; changes while button held are ignored.
- A, B, sel keep last loaded values across sequences; ALU sees them continuously.
- No arithmetic in this block; i_result passed through unmodified at full NB_DATA width.
- Reset: o_dataA, o_dataB, o_sel, o_result = 0; o_valid = 0; state = ST_A; all synchroniser/edge flops = 0. A button held high across reset release therefore yields one pulse after release.
- Reset mid-sequence aborts: partially loaded values cleared, no o_valid.

## Timing
- Button first sampled high at edge k: sync2 high after k+1, pulse high during cycle k+1..k+2, register load at edge k+2.
- A/B/sel visible on outputs after edge k+2 of their button.
- Execute: sel loads at edge k+2 (state -> ST_EXEC), o_result and o_valid update at edge k+3; o_valid deasserts at edge k+4; state ST_A after k+3.
- ALU path is combinational between o_dataA/o_dataB/o_sel and i_result; it has the full ST_EXEC cycle to settle.
- Minimum back-to-back full sequence: limited only by button presses; next pulse_a accepted from the cycle after k+3.

## Test plan
- Reset: assert i_reset asynchronously mid-cycle -> all outputs 0, o_state=00 immediately, no clock needed.
- Add: i_data=0x0005 press A, 0x0003 press B, 0x0000 press op -> o_dataA=0x0005, o_dataB=0x0003, o_sel=00, o_result=0x0008, o_valid high exactly one cycle, 3 edges after op first sampled.
- Subtract wrap: A=0x0003, B=0x0005, op=01 -> o_result=0xFFFE; then op sequence with AND (A=0xF0F0, B=0x0FF0, op=10) -> 0x00F0.
- Out-of-order: in ST_A press op then B -> o_state stays 00, registers unchanged, no o_valid.
- Held button: hold i_btn_a 20 cycles while i_data changes 0x1111 -> 0x2222 after 5 cycles -> single load, o_dataA=0x1111, state 01.
- Reset in ST_OP after A=0x00AA, B=0x0055 loaded -> all registers 0, o_state=00, no o_valid; fresh sequence afterwards completes correctly.
